psum_accum_ctrl: RTL and testbench

- Sequences the shared 16-bit Signed_Adder datapath to accumulate a run-time-configured number of signed partial sums (CiM column outputs) into one BitNet output element.
- Sits between the CiM macro readout (valid/ready stream) and the output buffer.
- Owns the accumulator register, beat counter, signed-overflow flag and the result handshake.

---
 rtl/psum_accum_pkg.sv | 18 +
 rtl/psum_accum_ctrl_adder.sv | 12 +
 rtl/psum_accum_ctrl.sv | 111 +++++++++++
 tb/tb_psum_accum_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_pkg.sv
// Shared definitions for the partial-sum accumulation path: FSM encoding and
// default datapath widths, reused by the output buffer and the bench.
package psum_accum_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        DONE  = ST_DONE
    } psum_state_e;

endpackage

// File: rtl/psum_accum_ctrl_adder.sv
// Signed_Adder: shared two's-complement adder, modular (wrap-around) result.
module Signed_Adder #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] in1,
    input  logic signed [WIDTH-1:0] in2,
    output logic signed [WIDTH-1:0] sum
);

    assign sum = in1 + in2;

endmodule

// File: rtl/psum_accum_ctrl.sv
// Accumulates a configured number of signed partial sums into one output
// element, tracking sticky signed overflow and handing the result downstream.
module psum_accum_ctrl
    import psum_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cfg_len,
    input  logic                    clear,
    output logic                    busy,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_ovf,
    input  logic                    out_ready
);

    // Signed overflow: operands share a sign and the sum's sign differs.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [1:0]              state;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        len_q;
    logic                    ovf;
    logic                    ovf_next;
    logic                    beat;
    logic                    last_beat;

    Signed_Adder #(.WIDTH(WIDTH)) u_adder (
        .in1 (acc),
        .in2 (in_data),
        .sum (sum)
    );

    // Handshake outputs decode straight from state: no path from in_valid/out_ready.
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_ACCUM) || (state == ST_DONE);

    assign beat      = in_valid && in_ready;
    assign ovf_next  = ovf | add_ovf(acc, in_data, sum);
    assign last_beat = (cnt == len_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            ovf      <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (clear) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            len_q <= cfg_len;
                            acc   <= '0;
                            cnt   <= '0;
                            ovf   <= 1'b0;
                            state <= ST_ACCUM;
                        end else begin
                            out_data <= '0;
                            out_ovf  <= 1'b0;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc <= sum;
                        ovf <= ovf_next;
                        // Counter holds on the final beat so it never passes len_q-1.
                        if (last_beat) begin
                            out_data <= sum;
                            out_ovf  <= ovf_next;
                            state    <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Bench for psum_accum_ctrl: table of runs plus hand-written corner sequences,
// results checked through an expected-result queue at the output handshake.
module tb_psum_accum_ctrl;
    import psum_accum_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        clear;
    logic        busy;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        o;
    } res_t;

    res_t exp_q[$];

    typedef struct {
        int          len;
        logic [15:0] b[4];
        int          gap;
        int          rdy;
        logic [15:0] exp_d;
        logic        exp_o;
    } vec_t;

    vec_t vecs[7];

    psum_accum_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .clear     (clear),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic vec_t mk(input int len, input int b0, input int b1, input int b2,
                                input int b3, input int gap, input int rdy,
                                input int ed, input logic eo);
        vec_t v;
        v.len   = len;
        v.b[0]  = 16'(b0);
        v.b[1]  = 16'(b1);
        v.b[2]  = 16'(b2);
        v.b[3]  = 16'(b3);
        v.gap   = gap;
        v.rdy   = rdy;
        v.exp_d = 16'(ed);
        v.exp_o = eo;
        return v;
    endfunction

    // Output-side scoreboard: stability while stalled, pop on handshake.
    logic        prev_held = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_ovf  = 1'b0;

    always @(negedge clk) begin
        if (out_valid) begin
            check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
            if (prev_held) begin
                check("hold_data", {16'b0, out_data}, {16'b0, prev_data});
                check("hold_ovf", {31'b0, out_ovf}, {31'b0, prev_ovf});
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0h with nothing expected", out_data);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("result_data", {16'b0, out_data}, {16'b0, r.d});
                    check("result_ovf", {31'b0, out_ovf}, {31'b0, r.o});
                end
            end
        end
        prev_held <= out_valid && !out_ready;
        prev_data <= out_data;
        prev_ovf  <= out_ovf;
    end

    // Caller and callee both sit at 1 time unit after a rising edge.
    task automatic send_beat(input logic [15:0] v);
        int   n  = 0;
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        while (!ok && n < 20) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) fail_now("beat_accept");
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        out_ready = (v.rdy == 0);
        start     = 1'b1;
        cfg_len   = 8'(v.len);
        exp_q.push_back({v.exp_d, v.exp_o});
        @(posedge clk);
        #1;
        start   = 1'b0;
        cfg_len = 8'hAA;
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) repeat (v.gap) begin
                @(posedge clk);
                #1;
            end
            send_beat(v.b[i]);
        end
        check("latency_valid", {31'b0, out_valid}, 32'd1);
        check("busy_in_done", {31'b0, busy}, 32'd1);
        repeat (v.rdy) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle("done_exit");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(4, 10, -3, 7, 1, 0, 0, 15, 1'b0);
        vecs[1] = mk(3, 5, 5, 5, 0, 2, 5, 15, 1'b0);
        vecs[2] = mk(2, 32767, 1, 0, 0, 0, 0, -32768, 1'b1);
        vecs[3] = mk(1, -5, 0, 0, 0, 0, 0, -5, 1'b0);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        vecs[5] = mk(3, -100, 50, -20, 0, 1, 2, -70, 1'b0);
        vecs[6] = mk(2, -32768, -1, 0, 0, 0, 0, 32767, 1'b1);

        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Longest run: 255 unit beats, count must land exactly.
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_len   = 8'd255;
        exp_q.push_back({16'd255, 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 255; i++) send_beat(16'd1);
        check("max_latency_valid", {31'b0, out_valid}, 32'd1);
        wait_idle("max_done_exit");

        // Abort mid-run, then a clean single-beat run.
        start   = 1'b1;
        cfg_len = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(16'd100);
        send_beat(16'd200);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        run_vec(mk(1, 9, 0, 0, 0, 0, 0, 9, 1'b0));

        // Clear while holding a result: result is dropped.
        out_ready = 1'b0;
        start     = 1'b1;
        cfg_len   = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(16'd3);
        check("drop_valid", {31'b0, out_valid}, 32'd1);
        check("drop_data", {16'b0, out_data}, 32'd3);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_done_valid", {31'b0, out_valid}, 32'd0);
        check("clear_done_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a cycle during ACCUM.
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_len   = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(16'd1);
        send_beat(16'd2);
        in_valid = 1'b1;
        in_data  = 16'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd0);
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_out_data", {16'b0, out_data}, 32'd0);
        check("arst_out_ovf", {31'b0, out_ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_data = 16'd7;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_in_ready", {31'b0, in_ready}, 32'd0);
            check("post_rst_busy", {31'b0, busy}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        run_vec(mk(2, 4, -9, 0, 0, 0, 0, -5, 1'b0));

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
